pipelined_cla_addsub: RTL and testbench
=======================================

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 Parameter GROUP, default 4: carry-lookahead group size in bits.
REQ-003 Parameter STAGES, default 2: pipeline register stages, each one WIDTH/STAGES-bit slice; WIDTH % (GROUP*STAGES) SHALL equal 0, else elaboration error.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operand beat offered.
REQ-007 in_ready  output  1  block accepts beat this cycle.
REQ-008 op_sub  input  1  0 = d1+d2, 1 = d1-d2.
REQ-009 d1  input  WIDTH  first operand.
REQ-010 d2  input  WIDTH  second operand.
REQ-011 out_valid  output  1  result beat valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum == 0.

Function
REQ-017 Subtraction SHALL be d1 + ~d2 + 1 (inverted d2, carry-in 1), computed on the operands of the accepted beat, never on previously registered values.
REQ-018 Each slice SHALL use GROUP-bit lookahead generate/propagate logic, groups rippling within the slice.
REQ-019 Stage k SHALL add slice k; its carry-out is registered and feeds stage k+1; unprocessed upper operand slices and op_sub travel with the beat.
REQ-020 A beat accepted when in_valid && in_ready SHALL appear on out_valid exactly STAGES cycles later if out_ready held 1.
REQ-021 Pipeline advance SHALL be global: advance = !out_valid || out_ready; in_ready = advance (combinational, no combinational path from in_valid).
REQ-022 When advance is 0 all stage registers, including sum/flags, SHALL hold; outputs stable while out_valid && !out_ready.
REQ-023 Stage valid bits SHALL propagate bubbles; an idle input cycle with advance=1 inserts a bubble; no beat dropped or duplicated; order preserved.
REQ-024 Throughput SHALL be one beat per cycle with out_ready=1 continuously.
REQ-025 cout SHALL equal carry out of bit WIDTH-1 including carry-in.
REQ-026 ovf SHALL equal carry into MSB XOR carry out of MSB.
REQ-027 zero SHALL be computed in the final stage from the complete registered sum.
REQ-028 sum, cout, ovf, zero SHALL be don't-care-free: registered, and retain last value when out_valid=0.
REQ-029 STAGES=1 SHALL degenerate to a single registered full-width adder, latency 1.

Reset
REQ-030 rst_n low SHALL immediately clear all stage valid bits, out_valid=0, sum=0, cout=0, ovf=0, zero=0, independent of clk.
REQ-031 While rst_n low, in_ready SHALL be 0; beats in flight at reset assertion SHALL be discarded.
REQ-032 First beat SHALL be accepted on the first rising edge after rst_n deasserts with in_valid=1.

Verification (WIDTH=32, GROUP=4, STAGES=2)
REQ-033 add 0xFFFFFFFF + 0x00000001 -> 2 cycles later sum=0x00000000, cout=1, ovf=0, zero=1.
REQ-034 add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, cout=0, ovf=1, zero=0.
REQ-035 sub 5 - 7 -> sum=0xFFFFFFFE, cout=0, ovf=0; sub 7 - 7 -> sum=0, cout=1, zero=1.
REQ-036 out_ready=0, four back-to-back beats offered -> in_ready falls after two accepted, outputs frozen; out_ready=1 -> all beats emerge in order, one per cycle, none lost.
REQ-037 rst_n pulsed low with two beats in flight -> out_valid=0 and flags 0 immediately, neither beat ever emerges; next beat after release returns correct result at latency 2.
REQ-038 10k random beats, random op_sub, random in_valid/out_ready -> every result matches reference model d1±d2 with flags, count and order exact; repeat with STAGES=1 and STAGES=4.

Source files
------------

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: each stage adds one WIDTH/STAGES slice,
// the carry and the unprocessed operand slices ride with the beat under a global stall.
module pipelined_cla_addsub #(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;

  if (WIDTH % (GROUP * STAGES) != 0) begin : g_param_check
    $error("pipelined_cla_addsub: WIDTH must be a multiple of GROUP*STAGES");
  end

  // Lookahead inside each GROUP-bit group, group carries ripple across the slice.
  function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a,
                                            input logic [SW-1:0] b,
                                            input logic          cin);
    logic [SW-1:0] g, p, s;
    logic          cg, c, t;
    g  = a & b;
    p  = a ^ b;
    s  = '0;
    cg = cin;
    for (int grp = 0; grp < NG; grp++) begin
      for (int i = 0; i <= GROUP; i++) begin
        c = cg;
        for (int j = 0; j < i; j++) c = c & p[grp*GROUP+j];
        for (int j = 0; j < i; j++) begin
          t = g[grp*GROUP+j];
          for (int m = j + 1; m < i; m++) t = t & p[grp*GROUP+m];
          c = c | t;
        end
        if (i < GROUP) s[grp*GROUP+i] = p[grp*GROUP+i] ^ c;
        else           cg = c;
      end
    end
    return {cg, s};
  endfunction

  logic adv;
  logic ovf_q, zero_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && rst_n;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic               v_i, op_i, c_i;
    logic [WIDTH-LO-1:0] a_i, b_i;
    logic [HI-1:0]      s_new;
    logic [SW:0]        r;
    logic               vld_d, vld_q, c_d, c_q;
    logic [HI-1:0]      s_d, s_q;

    assign r = cla_slice(a_i[SW-1:0], b_i[SW-1:0] ^ {SW{op_i}}, c_i);

    if (k == 0) begin : g_src
      assign v_i   = in_valid;
      assign op_i  = op_sub;
      assign c_i   = op_sub;
      assign a_i   = d1;
      assign b_i   = d2;
      assign s_new = r[SW-1:0];
    end else begin : g_src
      assign v_i   = g_st[k-1].vld_q;
      assign op_i  = g_st[k-1].g_ops.op_q;
      assign c_i   = g_st[k-1].c_q;
      assign a_i   = g_st[k-1].g_ops.a_q;
      assign b_i   = g_st[k-1].g_ops.b_q;
      assign s_new = {r[SW-1:0], g_st[k-1].s_q};
    end

    always_comb begin
      vld_d = adv ? v_i : vld_q;
      c_d   = c_q;
      s_d   = s_q;
      if (adv && v_i) begin
        c_d = r[SW];
        s_d = s_new;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        c_q   <= 1'b0;
        s_q   <= '0;
      end else begin
        vld_q <= vld_d;
        c_q   <= c_d;
        s_q   <= s_d;
      end
    end

    // Upper operand slices still waiting for a later stage.
    if (k < STAGES - 1) begin : g_ops
      logic [WIDTH-HI-1:0] a_d, a_q, b_d, b_q;
      logic                op_d, op_q;

      always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        op_d = op_q;
        if (adv && v_i) begin
          a_d  = a_i[WIDTH-LO-1:SW];
          b_d  = b_i[WIDTH-LO-1:SW];
          op_d = op_i;
        end
      end

      always_ff @(posedge clk) begin
        a_q  <= a_d;
        b_q  <= b_d;
        op_q <= op_d;
      end
    end

    if (k == STAGES - 1) begin : g_flags
      logic ovf_d, zero_d, c_msb;

      // Carry into the MSB recovered from the MSB sum bit and its operands.
      always_comb begin
        c_msb  = a_i[WIDTH-LO-1] ^ b_i[WIDTH-LO-1] ^ op_i ^ r[SW-1];
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (adv && v_i) begin
          ovf_d  = r[SW] ^ c_msb;
          zero_d = (s_new == '0);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].vld_q;
  assign sum       = g_st[STAGES-1].s_q;
  assign cout      = g_st[STAGES-1].c_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: directed corner cases on the STAGES=2 instance plus a
// randomized scoreboard run against STAGES=2, 1 and 4 instances sharing one stimulus bus.
module tb_pipelined_cla_addsub;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        op_sub;
  logic [31:0] d1, d2;
  logic        out_ready;
  logic [2:0]  in_ready_w, out_valid_w, cout_w, ovf_w, zero_w;
  logic [31:0] sum_w [3];

  int n_checks = 0;
  int n_fail   = 0;
  int n_in  [3];
  int n_out [3];
  res_t exp_q [3][$];
  logic  stall_prev [3];
  logic [35:0] held [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int ST = (gi == 0) ? 2 : ((gi == 1) ? 1 : 4);
    pipelined_cla_addsub #(.WIDTH(32), .GROUP(4), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[gi]),
      .op_sub    (op_sub),
      .d1        (d1),
      .d2        (d2),
      .out_valid (out_valid_w[gi]),
      .out_ready (out_ready),
      .sum       (sum_w[gi]),
      .cout      (cout_w[gi]),
      .ovf       (ovf_w[gi]),
      .zero      (zero_w[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic res_t ref_model(input logic op, input logic [31:0] a, input logic [31:0] b);
    res_t        r;
    longint      sa, sb, sr;
    logic [32:0] u;
    sa = $signed(a);
    sb = $signed(b);
    if (op) begin
      sr  = sa - sb;
      r.s = a - b;
      r.c = (a >= b);
    end else begin
      sr  = sa + sb;
      u   = {1'b0, a} + {1'b0, b};
      r.s = u[31:0];
      r.c = u[32];
    end
    r.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    r.z = (r.s == 32'd0);
    return r;
  endfunction

  function automatic logic [34:0] dut_res(input int i);
    return {sum_w[i], cout_w[i], ovf_w[i], zero_w[i]};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard: acceptance and consumption both decided at the coming rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        exp_q[i].delete();
        stall_prev[i] = 1'b0;
        n_in[i]  = 0;
        n_out[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (stall_prev[i])
          check_eq($sformatf("sb%0d_hold", i), {dut_res(i), out_valid_w[i]}, held[i]);
        if (out_valid_w[i] && out_ready) begin
          if (exp_q[i].size() == 0) begin
            check_eq($sformatf("sb%0d_unexpected_valid", i), out_valid_w[i], 0);
          end else begin
            check_eq($sformatf("sb%0d_res", i), dut_res(i), exp_q[i].pop_front());
            n_out[i]++;
          end
        end
        stall_prev[i] = out_valid_w[i] && !out_ready;
        held[i]       = {dut_res(i), out_valid_w[i]};
        if (in_valid && in_ready_w[i]) begin
          exp_q[i].push_back(ref_model(op_sub, d1, d2));
          n_in[i]++;
        end
      end
    end
  end

  // Call one time unit after a rising edge; checks latency-2 result on instance 0.
  task automatic send_check(input string tag, input logic op, input logic [31:0] a,
                            input logic [31:0] b);
    res_t e;
    e        = ref_model(op, a, b);
    in_valid = 1'b1;
    op_sub   = op;
    d1       = a;
    d2       = b;
    @(negedge clk);
    check_eq({tag, "_in_ready"}, in_ready_w[0], 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq({tag, "_not_early"}, out_valid_w[0], 0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, out_valid_w[0], 1);
    check_eq({tag, "_sum"},  sum_w[0],  e.s);
    check_eq({tag, "_cout"}, cout_w[0], e.c);
    check_eq({tag, "_ovf"},  ovf_w[0],  e.o);
    check_eq({tag, "_zero"}, zero_w[0], e.z);
  endtask

  initial begin
    int   j, k, first, last, cyc, base;
    res_t e36 [4];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_sub    = 1'b0;
    d1        = '0;
    d2        = '0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", in_ready_w[0], 0);
    check_eq("rst_out_valid", out_valid_w, 3'b000);
    check_eq("rst_flags", dut_res(0), 35'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send_check("add_wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);
    send_check("add_ovf",  1'b0, 32'h7FFF_FFFF, 32'h0000_0001);
    send_check("sub_neg",  1'b1, 32'd5, 32'd7);
    send_check("sub_zero", 1'b1, 32'd7, 32'd7);
    @(posedge clk); #1;

    // Back-pressure: four beats offered while the consumer stalls.
    for (int i = 0; i < 4; i++) e36[i] = ref_model(1'b0, 32'h1111_1111 * (i + 1), i + 3);
    out_ready = 1'b0;
    j = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (j < 4);
      op_sub   = 1'b0;
      d1       = 32'h1111_1111 * (j + 1);
      d2       = j + 3;
      @(negedge clk);
      if (in_valid && in_ready_w[0]) j++;
      @(posedge clk); #1;
    end
    check_eq("stall_accepted", j, 2);
    check_eq("stall_in_ready", in_ready_w[0], 0);
    check_eq("stall_valid", out_valid_w[0], 1);
    check_eq("stall_head", dut_res(0), e36[0]);
    out_ready = 1'b1;
    k = 0; first = -1; last = -1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (j < 4);
      d1       = 32'h1111_1111 * (j + 1);
      d2       = j + 3;
      @(negedge clk);
      if (in_valid && in_ready_w[0]) j++;
      if (out_valid_w[0]) begin
        if (k < 4) check_eq($sformatf("drain_beat%0d", k), dut_res(0), e36[k]);
        if (k == 0) first = c;
        last = c;
        k++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check_eq("drain_count", k, 4);
    check_eq("drain_accepted", j, 4);
    check_eq("drain_back_to_back", last - first, 3);

    // Reset with two beats in flight.
    in_valid = 1'b1; op_sub = 1'b0; d1 = 32'd100; d2 = 32'd23;
    @(posedge clk); #1;
    d1 = 32'd200; d2 = 32'd45;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid_w, 3'b000);
    check_eq("arst_flags", dut_res(0), 35'd0);
    check_eq("arst_in_ready", in_ready_w[0], 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_eq("arst_no_ghost", out_valid_w[0], 0);
    end
    @(posedge clk); #1;
    send_check("post_rst", 1'b1, 32'h8000_0000, 32'h0000_0001);
    @(posedge clk); #1;

    // Random traffic with random back-pressure on all three depths.
    base = n_out[0];
    cyc  = 0;
    while ((n_out[0] - base) < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      op_sub    = $urandom_range(0, 1);
      d1        = pick();
      d2        = pick();
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("rand_budget", (n_out[0] - base) >= 10000, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("sb%0d_leftover", i), exp_q[i].size(), 0);
      check_eq($sformatf("sb%0d_count", i), n_out[i], n_in[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
